remux_gray_8to1: RTL
====================

Name: remux_gray_8to1

Overview:
- Recombines the 8 parallel per-channel pulse streams produced by the gray-select 1-to-8 demux back into one ordered sample stream.
- Each of the 8 interleaved sub-channels delivers a W-bit result with a one-cycle valid pulse.
- The block holds one result per channel and emits the results in channel order 0..7, wrapping, on a valid/ready output interface.
- Alongside each output it gives the channel's 3-bit gray select code, and it flags overflow and out-of-order arrival.

Parameters:
W, 8, data width of each channel result.

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
ch_data[0:7]  input  W each  per-channel result; index = demux output index
ch_valid[0:7]  input  1 each  one-cycle pulse; ch_data[i] is valid this cycle
out_data  output  W  result at read pointer
out_valid  output  1  out_data holds a result
out_ready  input  1  downstream accepts; transfer = out_valid && out_ready
out_ch  output  3  gray code of read index (0:000 1:001 2:011 3:010 4:110 5:111 6:101 7:100)
occupancy  output  4  number of full slots, 0..8
overflow_err  output  1  sticky: result dropped on a full slot
order_err  output  1  sticky: arrival not on the expected channel, or more than one ch_valid bit set in a cycle
err_clr  input  1  synchronous clear of both sticky flags

Behaviour:
- Reset (async assert, sync-safe deassert):
  - all slot registers = 0; full[7:0] = 0
  - rd_idx = 0; exp_idx = 0
  - out_valid = 0, out_data = 0, out_ch = 000, occupancy = 0, both error flags = 0
- Reset asserted mid-operation discards all held results immediately.
- Slot write: when ch_valid[i]=1:
  - full[i]=0, or slot i is drained this same cycle: slot[i] <= ch_data[i], full[i] <= 1.
  - Otherwise the new data is dropped, slot[i] keeps its old value, and overflow_err is set.
- Several ch_valid bits in one cycle: every asserted slot is written under the rule above, and order_err is set.
- Output is combinational from the registered state:
  - out_valid = full[rd_idx], out_data = slot[rd_idx], out_ch = gray(rd_idx).
  - Latency from a ch_valid pulse to out_valid is 1 cycle when that slot is at rd_idx.
- Drain on a transfer: full[rd_idx] <= 0 (unless reloaded the same cycle), and rd_idx <= rd_idx+1 mod 8 (7 wraps to 0).
- Order-independent read:
  - The read pointer never skips. If full[rd_idx]=0, output stalls even when other slots are full.
  - out_data must stay stable while out_valid=1 and out_ready=0.
- Expected-arrival tracking:
  - On any cycle with at least one ch_valid bit set, exp_idx <= exp_idx+1 mod 8.
  - If that cycle's bits are not exactly {exp_idx}, order_err is set.
- Sticky flags: err_clr clears them; if a new error occurs in the same cycle as err_clr, the error wins and the flag stays 1.
- occupancy = popcount(full), registered, updated the same edge as full.
- Gray conversion is g = b ^ (b>>1), 3 bits; out_ch changes only when rd_idx changes.

Decomposition:
- Package remux_gray_pkg:
  - localparam NCH=8 and SEL_W=3
  - function bin2gray3 and function gray2bin3
  - typedef logic [SEL_W-1:0] sel_t
- Sub-module gray_ptr_3b:
  - 3-bit mod-8 binary counter with enable and async active-low reset
  - outputs both binary and gray
  - instantiated twice, for rd_idx and exp_idx

Test Plan:
1. Reset then ch_valid pulses on channels 0..7 in consecutive cycles, data 0x10..0x17, with out_ready=1 → outputs 0x10..0x17 one per cycle, out_ch 000,001,011,010,110,111,101,100, then rd_idx wraps to 0; both error flags stay 0.
2. out_ready=0, pulse all 8 channels in order → occupancy=8. Pulse ch0 again with 0xAA → overflow_err=1 and slot0 keeps its original value. Raise out_ready → the original 8 values come out in order.
3. Pulse ch2 first (data 0x33) with ch0 expected → order_err=1 and out_valid=0 (rd_idx=0 is empty). Then pulse ch0 and ch1 → outputs 0x(ch0), 0x(ch1), 0x33 in that order.
4. Slot at rd_idx is full, out_ready=1, and the same channel pulses new data in the same cycle → the old value is transferred, the new value is held, full stays 1, overflow_err=0.
5. Assert err_clr while a new overflow occurs → overflow_err stays 1. err_clr alone next cycle → both flags become 0.
6. Assert rst_n=0 mid-stream with occupancy=5 → immediately occupancy=0, out_valid=0, out_ch=000, flags 0.

Source files
------------

// File: rtl/remux_gray_8to1_pkg.sv
// Shared types and gray-code helpers for the 8-to-1 gray-select remux.
package remux_gray_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic sel_t bin2gray3(input sel_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic sel_t gray2bin3(input sel_t g);
        sel_t b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

endpackage

// File: rtl/remux_gray_8to1_if.sv
// Per-channel input pulses plus the valid/ready output stream and status flags.
interface remux_gray_8to1_if #(parameter int W = 8);
    import remux_gray_pkg::*;

    logic [W-1:0]   ch_data [NCH];
    logic [NCH-1:0] ch_valid;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    sel_t           out_ch;
    logic [3:0]     occupancy;
    logic           overflow_err;
    logic           order_err;
    logic           err_clr;

    modport master (
        output ch_data, ch_valid, out_ready, err_clr,
        input  out_data, out_valid, out_ch, occupancy, overflow_err, order_err
    );

    modport slave (
        input  ch_data, ch_valid, out_ready, err_clr,
        output out_data, out_valid, out_ch, occupancy, overflow_err, order_err
    );

endinterface

// File: rtl/remux_gray_8to1_gray_ptr.sv
// Mod-8 pointer held in gray code; the binary view is decoded from the state.
module gray_ptr_3b
    import remux_gray_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output sel_t bin,
    output sel_t gray
);

    sel_t gray_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q <= '0;
        end else if (en) begin
            gray_q <= bin2gray3(bin + sel_t'(1));
        end
    end

    assign gray = gray_q;
    assign bin  = gray2bin3(gray_q);

endmodule

// File: rtl/remux_gray_8to1.sv
// Holds one result per channel and replays them strictly in channel order 0..7,
// flagging dropped results and arrivals that break the expected rotation.
module remux_gray_8to1
    import remux_gray_pkg::*;
#(
    parameter int W = 8
)(
    input  logic               clk,
    input  logic               rst_n,
    remux_gray_8to1_if.slave   bus
);

    logic [W-1:0]   slot [NCH];
    logic [NCH-1:0] full;
    logic [NCH-1:0] full_nxt;
    logic [NCH-1:0] drain;
    logic [NCH-1:0] write_en;
    logic [NCH-1:0] exp_mask;
    logic [3:0]     occ_q;
    logic [3:0]     occ_nxt;
    logic           xfer;
    logic           any_valid;
    logic           ovf_evt;
    logic           ord_evt;
    logic           overflow_q;
    logic           order_q;
    sel_t           rd_idx;
    sel_t           rd_gray;
    sel_t           exp_idx;
    sel_t           unused_exp_gray;

    gray_ptr_3b u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (xfer),
        .bin   (rd_idx),
        .gray  (rd_gray)
    );

    gray_ptr_3b u_exp_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (any_valid),
        .bin   (exp_idx),
        .gray  (unused_exp_gray)
    );

    // A slot being drained this cycle may be refilled at the same edge.
    always_comb begin
        xfer      = full[rd_idx] && bus.out_ready;
        any_valid = |bus.ch_valid;
        drain     = '0;
        if (xfer) begin
            drain[rd_idx] = 1'b1;
        end
        write_en  = bus.ch_valid & (~full | drain);
        full_nxt  = write_en | (full & ~drain);
        ovf_evt   = |(bus.ch_valid & full & ~drain);
        exp_mask  = '0;
        exp_mask[exp_idx] = 1'b1;
        ord_evt   = any_valid && (bus.ch_valid != exp_mask);
        occ_nxt   = '0;
        for (int i = 0; i < NCH; i++) begin
            occ_nxt = occ_nxt + {3'b000, full_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                slot[i] <= '0;
            end
            full       <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            order_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (write_en[i]) begin
                    slot[i] <= bus.ch_data[i];
                end
            end
            full       <= full_nxt;
            occ_q      <= occ_nxt;
            // A fresh error outranks a simultaneous clear.
            overflow_q <= ovf_evt | (overflow_q & ~bus.err_clr);
            order_q    <= ord_evt | (order_q & ~bus.err_clr);
        end
    end

    assign bus.out_valid    = full[rd_idx];
    assign bus.out_data     = slot[rd_idx];
    assign bus.out_ch       = rd_gray;
    assign bus.occupancy    = occ_q;
    assign bus.overflow_err = overflow_q;
    assign bus.order_err    = order_q;

endmodule
